rob_param: RTL and testbench
============================

// Module: rob_param
// PURPOSE
//  Parametrised reorder buffer, next generation of the core's ROB. Issues in order from the decoder,
//  takes out-of-order completions from the ALU RS and the LSB, and retires in order to the regfile,
//  LSB and RAT. Adds three things: true full/empty via an occupancy counter, in-ROB branch-mispredict
//  detection with self-flush, and a held store-commit handshake.
// PARAMETERS
//  ENTRY_W   4      log2 depth; DEPTH = 2**ENTRY_W entries
//  DATA_W    32     result / PC width
//  RD_W      5      destination register index width
//  OP_STORE  3'd2   op_type code that marks a store
// PORTS
//  clk_in         in   1        clock, sole clock domain
//  rst_in         in   1        asynchronous, active-high reset
//  rdy_in         in   1        low = pause; all state held
//  issue_valid    in   1        allocate one entry this cycle
//  issue_pc       in   DATA_W   PC of the issued instruction
//  issue_pred_pc  in   DATA_W   predicted next PC
//  issue_rd       in   RD_W     destination reg (0 = none)
//  issue_op_type  in   3        op class
//  issue_entry    out  ENTRY_W  tag that an issue this cycle receives (= tail)
//  full           out  1        count == DEPTH
//  empty          out  1        count == 0
//  count          out  ENTRY_W+1  occupancy
//  alu_wb_valid/alu_wb_entry/alu_wb_result/alu_wb_next_pc  in  1/ENTRY_W/DATA_W/DATA_W  ALU completion
//  lsb_wb_valid/lsb_wb_entry/lsb_wb_result                 in  1/ENTRY_W/DATA_W          load completion
//  st_addr_valid/st_addr_entry                             in  1/ENTRY_W                 store address ready
//  store_done     in   1        memory controller finished the committed store
//  commit_valid   out  1        one-cycle retire pulse
//  commit_entry/commit_rd/commit_result/commit_op_type  out  ENTRY_W/RD_W/DATA_W/3  retired entry fields
//  rollback       out  1        one-cycle flush pulse
//  rollback_pc    out  DATA_W   redirect target
//  head_entry     out  ENTRY_W  oldest live tag
// BEHAVIOUR
//  - Reset (async): head = tail = count = 0; every valid/ready/mispred bit = 0; all outputs 0.
//  - Each entry holds: valid, ready, mispred, op_type, rd, pc, pred_pc, result, next_pc.
//  - Issue: when issue_valid & !full & rdy_in, write the entry at tail (ready = 0) and advance tail
//    mod DEPTH. Issue while full is dropped; the issuer must gate on full.
//  - Writeback: mark the entry ready and store the result. ALU also stores next_pc and sets
//    mispred = (alu_wb_next_pc != pred_pc). st_addr sets ready only. A write to an invalid entry is
//    ignored. If ALU and LSB hit the same entry in one cycle, LSB wins (protocol error; assertion).
//  - Commit: registered, at most one per cycle. Head commits when head valid & ready & !store_wait.
//    Next cycle: commit_valid = 1 with the head fields; head advances; the entry's valid bit clears.
//    Otherwise commit_valid = 0. A store commit sets store_wait. store_wait clears on store_done
//    (store_done on the same cycle as the store commit is honoured).
//  - Mispredict: committing an entry with mispred = 1 also drives rollback = 1 and
//    rollback_pc = next_pc in the same cycle as commit_valid. On that edge, all entries clear and
//    head = tail = count = 0; an issue arriving in the same cycle is discarded.
//  - Simultaneous issue + commit: count unchanged. Tail and head wrap mod DEPTH.
//  - rdy_in low: no issue, writeback or commit; commit_valid and rollback forced to 0.
//  - Latency: issue -> earliest commit = 2 cycles (writeback cycle + registered commit).
// CONFIGURATION
//  ROB_BYPASS_EN defined: a writeback whose tag equals head in cycle N lets head commit at edge N
//  (result forwarded from the wb port; ALU has priority for mispred). Removes 1 cycle of latency.
//  Undefined: head must be ready in stored state; writeback-to-commit takes at least 2 edges.
// TESTING
//  1 Reset mid-run with count=5 -> outputs 0 immediately (async); empty=1 after release.
//  2 Issue 16 with ENTRY_W=4 -> full=1, count=16; 17th issue ignored; tail wraps to 0.
//  3 Issue tags 0,1,2; wb order 2,0,1 -> commits 0,1,2 in order, one per cycle, results match.
//  4 Store at tag 0, ALU op at tag 1, both ready -> tag 1 held until store_done; then commits next edge.
//  5 Branch tag 1, pred 0x104, alu next_pc 0x200 -> commit tag1 with rollback=1, rollback_pc=0x200;
//    count=0 next cycle; entries 2..n never commit.
//  6 ROB_BYPASS_EN: wb to head tag in cycle N -> commit_valid at N+1; without the macro -> at N+2.

Source files
------------

// File: rtl/rob_param.sv
// rob_param -- parametrised reorder buffer.
//
// Instructions are allocated in order at the tail and complete out of order
// through three writeback ports: ALU result, LSB load result, and store-address
// ready. They retire in order from the head, one per cycle, through registered
// commit outputs. Branch mispredicts are detected inside the buffer: retiring an
// entry whose ALU next_pc differs from its predicted PC also pulses rollback and
// empties the whole buffer. A retired store holds further commits until the
// memory controller answers with store_done.
//
// Handshake semantics: an issue is accepted on a clock edge where issue_valid,
// rdy_in and !full are all high, and it is silently dropped otherwise; each
// writeback valid is a single-cycle strobe with no back-pressure; store_done is a
// single-cycle strobe that releases the held store commit.
//
// Ports
//   clk_in, rst_in (async, active high), rdy_in (low = hold every state bit)
//   issue_*        : allocation request, issue_entry = tag it will receive
//   full/empty/count : occupancy
//   alu_wb_*, lsb_wb_*, st_addr_* : completion strobes addressed by tag
//   store_done     : committed store has been performed
//   commit_*       : one-cycle retire pulse with the retired entry's fields
//   rollback, rollback_pc : one-cycle flush pulse and redirect target
//   head_entry     : oldest live tag
//   dbg_store_wait : a retired store is waiting for store_done
//
// Build option: define ROB_BYPASS_EN to let a writeback addressed to the head
// tag retire that entry on the same edge (one cycle less latency).

module rob_param #(
    parameter int         ENTRY_W  = 4,
    parameter int         DATA_W   = 32,
    parameter int         RD_W     = 5,
    parameter logic [2:0] OP_STORE = 3'd2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                issue_valid,
    input  logic [DATA_W-1:0]   issue_pc,
    input  logic [DATA_W-1:0]   issue_pred_pc,
    input  logic [RD_W-1:0]     issue_rd,
    input  logic [2:0]          issue_op_type,
    output logic [ENTRY_W-1:0]  issue_entry,
    output logic                full,
    output logic                empty,
    output logic [ENTRY_W:0]    count,
    input  logic                alu_wb_valid,
    input  logic [ENTRY_W-1:0]  alu_wb_entry,
    input  logic [DATA_W-1:0]   alu_wb_result,
    input  logic [DATA_W-1:0]   alu_wb_next_pc,
    input  logic                lsb_wb_valid,
    input  logic [ENTRY_W-1:0]  lsb_wb_entry,
    input  logic [DATA_W-1:0]   lsb_wb_result,
    input  logic                st_addr_valid,
    input  logic [ENTRY_W-1:0]  st_addr_entry,
    input  logic                store_done,
    output logic                commit_valid,
    output logic [ENTRY_W-1:0]  commit_entry,
    output logic [RD_W-1:0]     commit_rd,
    output logic [DATA_W-1:0]   commit_result,
    output logic [2:0]          commit_op_type,
    output logic [DATA_W-1:0]   commit_pc,
    output logic                rollback,
    output logic [DATA_W-1:0]   rollback_pc,
    output logic [ENTRY_W-1:0]  head_entry,
    output logic                dbg_store_wait
);

    localparam int DEPTH = 2 ** ENTRY_W;
    localparam logic [ENTRY_W:0]   DEPTH_CNT = (ENTRY_W + 1)'(DEPTH);
    localparam logic [ENTRY_W:0]   CNT_ONE   = (ENTRY_W + 1)'(1);
    localparam logic [ENTRY_W-1:0] PTR_ONE   = ENTRY_W'(1);

    // Control bits (reset) and payload arrays (no reset; only read when valid).
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  mispred_q;
    logic [2:0]        op_q      [DEPTH];
    logic [RD_W-1:0]   rd_q      [DEPTH];
    logic [DATA_W-1:0] pc_q      [DEPTH];
    logic [DATA_W-1:0] pred_pc_q [DEPTH];
    logic [DATA_W-1:0] result_q  [DEPTH];
    logic [DATA_W-1:0] next_pc_q [DEPTH];

    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] tail_q;
    logic [ENTRY_W:0]   count_q;
    logic               store_wait_q;

    logic               issue_fire;
    logic               commit_fire;
    logic               head_rdy;
    logic               head_mispred;
    logic [DATA_W-1:0]  head_result;
    logic [DATA_W-1:0]  head_next_pc;

    assign full           = (count_q == DEPTH_CNT);
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign issue_entry    = tail_q;
    assign head_entry     = head_q;
    assign dbg_store_wait = store_wait_q;
    assign issue_fire     = rdy_in && issue_valid && !full;

    // Head view used by the commit decision. With bypass, a writeback aimed at a
    // not-yet-ready head is forwarded; LSB wins the result, ALU supplies mispred.
    always_comb begin
        head_rdy     = ready_q[head_q];
        head_result  = result_q[head_q];
        head_mispred = mispred_q[head_q];
        head_next_pc = next_pc_q[head_q];
`ifdef ROB_BYPASS_EN
        if (!ready_q[head_q]) begin
            if (alu_wb_valid && (alu_wb_entry == head_q)) begin
                head_rdy     = 1'b1;
                head_result  = alu_wb_result;
                head_next_pc = alu_wb_next_pc;
                head_mispred = (alu_wb_next_pc != pred_pc_q[head_q]);
            end
            if (lsb_wb_valid && (lsb_wb_entry == head_q)) begin
                head_rdy    = 1'b1;
                head_result = lsb_wb_result;
            end
            if (st_addr_valid && (st_addr_entry == head_q)) begin
                head_rdy = 1'b1;
            end
        end
`endif
        // store_done releases a waiting store on the same edge it is seen.
        commit_fire = rdy_in && valid_q[head_q] && head_rdy &&
                      !(store_wait_q && !store_done);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q        <= '0;
            ready_q        <= '0;
            mispred_q      <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            store_wait_q   <= 1'b0;
            commit_valid   <= 1'b0;
            commit_entry   <= '0;
            commit_rd      <= '0;
            commit_result  <= '0;
            commit_op_type <= '0;
            commit_pc      <= '0;
            rollback       <= 1'b0;
            rollback_pc    <= '0;
        end else begin
            commit_valid <= 1'b0;
            rollback     <= 1'b0;
            if (rdy_in) begin
                if (issue_fire) begin
                    valid_q[tail_q]   <= 1'b1;
                    ready_q[tail_q]   <= 1'b0;
                    mispred_q[tail_q] <= 1'b0;
                    tail_q            <= tail_q + PTR_ONE;
                end
                if (alu_wb_valid && valid_q[alu_wb_entry]) begin
                    ready_q[alu_wb_entry]   <= 1'b1;
                    mispred_q[alu_wb_entry] <= (alu_wb_next_pc != pred_pc_q[alu_wb_entry]);
                end
                if (lsb_wb_valid && valid_q[lsb_wb_entry]) begin
                    ready_q[lsb_wb_entry] <= 1'b1;
                end
                if (st_addr_valid && valid_q[st_addr_entry]) begin
                    ready_q[st_addr_entry] <= 1'b1;
                end

                case ({issue_fire, commit_fire})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase

                if (store_done) begin
                    store_wait_q <= 1'b0;
                end

                if (commit_fire) begin
                    commit_valid    <= 1'b1;
                    commit_entry    <= head_q;
                    commit_rd       <= rd_q[head_q];
                    commit_result   <= head_result;
                    commit_op_type  <= op_q[head_q];
                    commit_pc       <= pc_q[head_q];
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + PTR_ONE;
                    // A store_done seen while nothing was waiting belongs to
                    // this store, so it never starts waiting.
                    if ((op_q[head_q] == OP_STORE) && !(store_done && !store_wait_q)) begin
                        store_wait_q <= 1'b1;
                    end
                    // Mispredicted retire: flush everything, including any
                    // issue accepted on this same edge.
                    if (head_mispred) begin
                        rollback    <= 1'b1;
                        rollback_pc <= head_next_pc;
                        valid_q     <= '0;
                        ready_q     <= '0;
                        mispred_q   <= '0;
                        head_q      <= '0;
                        tail_q      <= '0;
                        count_q     <= '0;
                    end
                end
            end
        end
    end

    // Payload storage. Stale writes into flushed or freed slots are harmless
    // because the slot's valid bit gates every later use.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (issue_fire) begin
                op_q[tail_q]      <= issue_op_type;
                rd_q[tail_q]      <= issue_rd;
                pc_q[tail_q]      <= issue_pc;
                pred_pc_q[tail_q] <= issue_pred_pc;
            end
            if (alu_wb_valid && valid_q[alu_wb_entry]) begin
                result_q[alu_wb_entry]  <= alu_wb_result;
                next_pc_q[alu_wb_entry] <= alu_wb_next_pc;
            end
            // Written after the ALU so the LSB result wins a same-tag collision.
            if (lsb_wb_valid && valid_q[lsb_wb_entry]) begin
                result_q[lsb_wb_entry] <= lsb_wb_result;
            end
        end
    end

    // Two completion units must never address the same tag in one cycle.
    a_wb_collision: assert property (@(posedge clk_in) disable iff (rst_in)
        !(alu_wb_valid && lsb_wb_valid && (alu_wb_entry == lsb_wb_entry)));

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed scenarios plus randomized traffic, every cycle
// checked against an in-order queue model of the reorder buffer.

module tb_rob_param;

    localparam int EW    = 4;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 16;
    localparam logic [2:0] OP_ALU   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_BR    = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    logic          rdy_in, issue_valid;
    logic [DW-1:0] issue_pc, issue_pred_pc;
    logic [RW-1:0] issue_rd;
    logic [2:0]    issue_op_type;
    logic [EW-1:0] issue_entry;
    logic          full, empty;
    logic [EW:0]   count;
    logic          alu_wb_valid;
    logic [EW-1:0] alu_wb_entry;
    logic [DW-1:0] alu_wb_result, alu_wb_next_pc;
    logic          lsb_wb_valid;
    logic [EW-1:0] lsb_wb_entry;
    logic [DW-1:0] lsb_wb_result;
    logic          st_addr_valid;
    logic [EW-1:0] st_addr_entry;
    logic          store_done;
    logic          commit_valid;
    logic [EW-1:0] commit_entry;
    logic [RW-1:0] commit_rd;
    logic [DW-1:0] commit_result;
    logic [2:0]    commit_op_type;
    logic [DW-1:0] commit_pc;
    logic          rollback;
    logic [DW-1:0] rollback_pc;
    logic [EW-1:0] head_entry;
    logic          dbg_store_wait;

    rob_param #(.ENTRY_W(EW), .DATA_W(DW), .RD_W(RW), .OP_STORE(OP_STORE)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_pred_pc(issue_pred_pc),
        .issue_rd(issue_rd), .issue_op_type(issue_op_type), .issue_entry(issue_entry),
        .full(full), .empty(empty), .count(count),
        .alu_wb_valid(alu_wb_valid), .alu_wb_entry(alu_wb_entry),
        .alu_wb_result(alu_wb_result), .alu_wb_next_pc(alu_wb_next_pc),
        .lsb_wb_valid(lsb_wb_valid), .lsb_wb_entry(lsb_wb_entry), .lsb_wb_result(lsb_wb_result),
        .st_addr_valid(st_addr_valid), .st_addr_entry(st_addr_entry),
        .store_done(store_done),
        .commit_valid(commit_valid), .commit_entry(commit_entry), .commit_rd(commit_rd),
        .commit_result(commit_result), .commit_op_type(commit_op_type), .commit_pc(commit_pc),
        .rollback(rollback), .rollback_pc(rollback_pc),
        .head_entry(head_entry), .dbg_store_wait(dbg_store_wait)
    );

    // ---------------- checker ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The buffer is an ordered list of live instructions; entry i carries tag
    // m_head + i. Expected commit/rollback outputs are produced per edge.
    typedef struct {
        logic [RW-1:0] rd;
        logic [2:0]    op;
        logic [DW-1:0] pc;
        logic [DW-1:0] pred_pc;
        logic [DW-1:0] result;
        logic [DW-1:0] next_pc;
        bit            ready;
        bit            mispred;
    } ent_t;

    ent_t          exp_q[$];
    logic [EW-1:0] m_head;
    bit            m_store_wait;
    bit            e_cv, e_rb;
    ent_t          e_ent;
    logic [EW-1:0] e_tag;

    function automatic int tag_index(input logic [EW-1:0] t);
        logic [EW-1:0] d;
        d = t - m_head;
        if (int'(d) < exp_q.size()) return int'(d);
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_head = '0;
        m_store_wait = 0;
        e_cv = 0;
        e_rb = 0;
    endtask

    task automatic model_step();
        ent_t h, e;
        bit   fire, can_issue, old_wait;
        int   idx;
        e_cv = 0;
        e_rb = 0;
        if (!rdy_in) return;
        fire = 0;
        can_issue = issue_valid && (exp_q.size() < DEPTH);
        if (exp_q.size() > 0) begin
            h = exp_q[0];
`ifdef ROB_BYPASS_EN
            if (!h.ready) begin
                if (alu_wb_valid && alu_wb_entry == m_head) begin
                    h.ready = 1; h.result = alu_wb_result; h.next_pc = alu_wb_next_pc;
                    h.mispred = (alu_wb_next_pc != h.pred_pc);
                end
                if (lsb_wb_valid && lsb_wb_entry == m_head) begin
                    h.ready = 1; h.result = lsb_wb_result;
                end
                if (st_addr_valid && st_addr_entry == m_head) h.ready = 1;
            end
`endif
            fire = h.ready && !(m_store_wait && !store_done);
        end
        if (alu_wb_valid) begin
            idx = tag_index(alu_wb_entry);
            if (idx >= 0) begin
                e = exp_q[idx];
                e.ready = 1; e.result = alu_wb_result; e.next_pc = alu_wb_next_pc;
                e.mispred = (alu_wb_next_pc != e.pred_pc);
                exp_q[idx] = e;
            end
        end
        if (lsb_wb_valid) begin
            idx = tag_index(lsb_wb_entry);
            if (idx >= 0) begin
                e = exp_q[idx]; e.ready = 1; e.result = lsb_wb_result; exp_q[idx] = e;
            end
        end
        if (st_addr_valid) begin
            idx = tag_index(st_addr_entry);
            if (idx >= 0) begin
                e = exp_q[idx]; e.ready = 1; exp_q[idx] = e;
            end
        end
        old_wait = m_store_wait;
        if (store_done) m_store_wait = 0;
        if (fire) begin
            void'(exp_q.pop_front());
            e_cv = 1; e_ent = h; e_tag = m_head;
            m_head = m_head + 4'd1;
            if (h.op == OP_STORE && !(store_done && !old_wait)) m_store_wait = 1;
            if (h.mispred) begin
                e_rb = 1;
                exp_q.delete();
                m_head = '0;
                can_issue = 0;
            end
        end
        if (can_issue) begin
            e.rd = issue_rd; e.op = issue_op_type; e.pc = issue_pc; e.pred_pc = issue_pred_pc;
            e.result = '0; e.next_pc = '0; e.ready = 0; e.mispred = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic compare();
        logic [EW-1:0] exp_tail;
        exp_tail = m_head + EW'(exp_q.size());
        check("count", count, 64'(exp_q.size()));
        check("full", full, exp_q.size() == DEPTH);
        check("empty", empty, exp_q.size() == 0);
        check("head_entry", head_entry, m_head);
        check("issue_entry", issue_entry, exp_tail);
        check("store_wait", dbg_store_wait, m_store_wait);
        check("commit_valid", commit_valid, e_cv);
        check("rollback", rollback, e_rb);
        if (e_cv) begin
            check("commit_entry", commit_entry, e_tag);
            check("commit_rd", commit_rd, e_ent.rd);
            check("commit_op", commit_op_type, e_ent.op);
            check("commit_pc", commit_pc, e_ent.pc);
            if (e_ent.op != OP_STORE) check("commit_result", commit_result, e_ent.result);
        end
        if (e_rb) check("rollback_pc", rollback_pc, e_ent.next_pc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rdy_in = 1; issue_valid = 0; issue_pc = '0; issue_pred_pc = '0; issue_rd = '0;
        issue_op_type = '0; alu_wb_valid = 0; alu_wb_entry = '0; alu_wb_result = '0;
        alu_wb_next_pc = '0; lsb_wb_valid = 0; lsb_wb_entry = '0; lsb_wb_result = '0;
        st_addr_valid = 0; st_addr_entry = '0; store_done = 0;
    endtask

    task automatic drv_issue(input logic [2:0] op, input logic [DW-1:0] pc, input logic [DW-1:0] pred);
        issue_valid = 1; issue_op_type = op; issue_pc = pc; issue_pred_pc = pred;
        issue_rd = RW'($urandom_range(0, 31));
    endtask

    task automatic drv_alu(input logic [EW-1:0] t, input logic [DW-1:0] res, input logic [DW-1:0] npc);
        alu_wb_valid = 1; alu_wb_entry = t; alu_wb_result = res; alu_wb_next_pc = npc;
    endtask

    task automatic step_cycle();
        model_step();
        @(posedge clk_in);
        #1;
        compare();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1;
        @(posedge clk_in);
        #1;
        rst_in = 0;
        model_reset();
        compare();
    endtask

    task automatic drive_random(input int issue_pct);
        int alu_c[$], lsb_c[$], st_c[$];
        int k, r;
        logic [DW-1:0] pc;
        idle_inputs();
        rdy_in = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 99) < issue_pct) begin
            r  = $urandom_range(0, 9);
            pc = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
            drv_issue(r < 4 ? OP_ALU : r < 6 ? OP_LOAD : r < 8 ? OP_STORE : OP_BR, pc, pc + 4);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!exp_q[i].ready) begin
                if (exp_q[i].op == OP_LOAD) lsb_c.push_back(i);
                else if (exp_q[i].op == OP_STORE) st_c.push_back(i);
                else alu_c.push_back(i);
            end
        end
        if (alu_c.size() > 0 && $urandom_range(0, 99) < 60) begin
            k = alu_c[$urandom_range(0, alu_c.size() - 1)];
            pc = exp_q[k].pred_pc;
            if (exp_q[k].op == OP_BR && $urandom_range(0, 4) == 0) pc = $urandom;
            drv_alu(m_head + EW'(k), $urandom, pc);
        end else if (exp_q.size() < DEPTH && $urandom_range(0, 9) == 0) begin
            // Stray writeback to a free slot must be ignored.
            drv_alu(m_head + EW'(exp_q.size()), $urandom, $urandom);
        end
        if (lsb_c.size() > 0 && $urandom_range(0, 99) < 50) begin
            k = lsb_c[$urandom_range(0, lsb_c.size() - 1)];
            lsb_wb_valid = 1; lsb_wb_entry = m_head + EW'(k); lsb_wb_result = $urandom;
        end
        if (st_c.size() > 0 && $urandom_range(0, 99) < 50) begin
            k = st_c[$urandom_range(0, st_c.size() - 1)];
            st_addr_valid = 1; st_addr_entry = m_head + EW'(k);
        end
        store_done = m_store_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
            drive_random(0);
            step_cycle();
        end
        check("drain_empty", empty, 1);
    endtask

    // ---------------- scenarios ----------------
    logic [EW-1:0] seen_tag[$];
    logic [DW-1:0] seen_res[$];
    bit            rb_seen;
    logic [EW-1:0] rb_tag;
    logic [DW-1:0] rb_pc;
    logic [EW:0]   rb_cnt;

    initial begin
        idle_inputs();
        do_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_cv", commit_valid, 0);

        // Async reset while five entries are live and a commit pulse is high.
        for (int i = 0; i < 5; i++) begin
            idle_inputs(); drv_issue(OP_ALU, 32'h100 + 4 * i, 32'h104 + 4 * i); step_cycle();
        end
        idle_inputs(); drv_issue(OP_ALU, 32'h114, 32'h118); drv_alu(4'd0, 32'h55, 32'h104); step_cycle();
        idle_inputs(); step_cycle();
        check("t1_count5", count, 5);
        check("t1_cv_pre", commit_valid, 1);
        #2 rst_in = 1;
        #1;
        check("t1_async_count", count, 0);
        check("t1_async_cv", commit_valid, 0);
        check("t1_async_head", head_entry, 0);
        check("t1_async_tail", issue_entry, 0);
        model_reset();
        @(posedge clk_in);
        #1 rst_in = 0;
        check("t1_empty_rel", empty, 1);

        // Fill to capacity, then one more issue is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs(); drv_issue(OP_ALU, 32'h400 + 4 * i, 32'h404 + 4 * i); step_cycle();
        end
        check("t2_count16", count, 16);
        check("t2_full", full, 1);
        check("t2_tail_wrap", issue_entry, 0);
        idle_inputs(); drv_issue(OP_ALU, 32'h500, 32'h504); step_cycle();
        check("t2_count17", count, 16);
        drain();

        // Out-of-order completion, in-order retire.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); drv_issue(OP_ALU, 32'h200 + 4 * i, 32'h204 + 4 * i); step_cycle();
        end
        seen_tag.delete(); seen_res.delete();
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            if (i == 0) drv_alu(4'd2, 32'hA2, 32'h20C);
            if (i == 1) drv_alu(4'd0, 32'hA0, 32'h204);
            if (i == 2) drv_alu(4'd1, 32'hA1, 32'h208);
            step_cycle();
            if (commit_valid) begin seen_tag.push_back(commit_entry); seen_res.push_back(commit_result); end
        end
        check("t3_ncommit", seen_tag.size(), 3);
        if (seen_tag.size() == 3) begin
            check("t3_order0", seen_tag[0], 0); check("t3_res0", seen_res[0], 32'hA0);
            check("t3_order1", seen_tag[1], 1); check("t3_res1", seen_res[1], 32'hA1);
            check("t3_order2", seen_tag[2], 2); check("t3_res2", seen_res[2], 32'hA2);
        end

        // Store commit holds the next retire until store_done.
        do_reset();
        idle_inputs(); drv_issue(OP_STORE, 32'h300, 32'h304); step_cycle();
        idle_inputs(); drv_issue(OP_ALU, 32'h304, 32'h308); step_cycle();
        idle_inputs(); st_addr_valid = 1; st_addr_entry = 4'd0; drv_alu(4'd1, 32'hB1, 32'h308); step_cycle();
`ifndef ROB_BYPASS_EN
        idle_inputs(); step_cycle();
`endif
        check("t4_store_cv", commit_valid, 1);
        check("t4_store_tag", commit_entry, 0);
        check("t4_store_op", commit_op_type, OP_STORE);
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); step_cycle();
            check("t4_hold", commit_valid, 0);
        end
        idle_inputs(); store_done = 1; step_cycle();
        check("t4_rel_cv", commit_valid, 1);
        check("t4_rel_tag", commit_entry, 1);
        check("t4_rel_res", commit_result, 32'hB1);

        // Branch mispredict at tag 1 flushes the buffer.
        do_reset();
        idle_inputs(); drv_issue(OP_ALU, 32'hF8, 32'hFC); step_cycle();
        idle_inputs(); drv_issue(OP_BR, 32'h100, 32'h104); step_cycle();
        idle_inputs(); drv_issue(OP_ALU, 32'h104, 32'h108); step_cycle();
        idle_inputs(); drv_issue(OP_ALU, 32'h108, 32'h10C); step_cycle();
        rb_seen = 0; rb_tag = '0; rb_pc = '0; rb_cnt = '0;
        for (int k = 0; k < 6 && !rb_seen; k++) begin
            idle_inputs();
            drv_issue(OP_ALU, 32'h800 + 4 * k, 32'h804 + 4 * k);
            if (k == 0) drv_alu(4'd0, 32'hC0, 32'hFC);
            if (k == 1) drv_alu(4'd1, 32'hC1, 32'h200);
            if (k == 2) drv_alu(4'd2, 32'hC2, 32'h108);
            if (k == 3) drv_alu(4'd3, 32'hC3, 32'h10C);
            step_cycle();
            if (rollback) begin rb_seen = 1; rb_tag = commit_entry; rb_pc = rollback_pc; rb_cnt = count; end
        end
        check("t5_rb_seen", rb_seen, 1);
        check("t5_rb_tag", rb_tag, 1);
        check("t5_rb_pc", rb_pc, 32'h200);
        check("t5_rb_count", rb_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); step_cycle();
            check("t5_no_commit", commit_valid, 0);
        end

        // Writeback-to-commit latency at the head.
        do_reset();
        idle_inputs(); drv_issue(OP_ALU, 32'h600, 32'h604); step_cycle();
        idle_inputs(); step_cycle();
        idle_inputs(); drv_alu(4'd0, 32'hD0, 32'h604); step_cycle();
`ifdef ROB_BYPASS_EN
        check("t6_cv_n1", commit_valid, 1);
        idle_inputs(); step_cycle();
        check("t6_cv_n2", commit_valid, 0);
`else
        check("t6_cv_n1", commit_valid, 0);
        idle_inputs(); step_cycle();
        check("t6_cv_n2", commit_valid, 1);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_random(45);
            step_cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
